// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: flash opcodes, request op encoding, sequencer state encoding,
// engine transaction lengths and a helper that left-aligns a bare opcode.
package spi_flash_pkg;

  // Flash instruction opcodes
  localparam logic [7:0] OPC_READ        = 8'h03;
  localparam logic [7:0] OPC_WRITE       = 8'h02;
  localparam logic [7:0] OPC_WREN        = 8'h06;
  localparam logic [7:0] OPC_READ_STATUS = 8'h05;
  localparam logic [7:0] OPC_CHIP_ERASE  = 8'h60;

  // Engine transaction lengths in bits
  localparam logic [6:0] LEN_BYTE   = 7'd8;
  localparam logic [6:0] LEN_STATUS = 7'd16;
  localparam logic [6:0] LEN_LONG   = 7'd64;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_STATUS  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WREN = 3'd1,
    S_OP   = 3'd2,
    S_GAP  = 3'd3,
    S_POLL = 3'd4,
    S_RESP = 3'd5
  } seq_state_t;

  // Opcode left-aligned in the 64-bit tx field; idle bits are driven high.
  function automatic logic [63:0] pad_cmd8(input logic [7:0] opc);
    return {opc, {56{1'b1}}};
  endfunction

  // READ_STATUS followed by one dummy byte clocking the status back.
  function automatic logic [63:0] status_tx();
    return {OPC_READ_STATUS, 8'hFF, {48{1'b1}}};
  endfunction

endpackage

// File: rtl/spi_flash_sequencer_gap_timer.sv
// gap_timer: down-counter that times the CS-high gap between status polls.
// Latency: load sets POLL_GAP-1; expired is high on the POLL_GAP-th enabled cycle.
// Backpressure: none; counts only while en is high and holds at zero.
// Ports: clk, rst (sync, active-high), load (restart count), en (count this
// cycle), expired (count has reached zero).
module gap_timer #(
  parameter int POLL_GAP = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(POLL_GAP - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: turns one read/program/erase/status request into a
// sequence of SPI engine transactions (WREN, op, timed status polls).
// Latency: one engine transaction per state; POLL_GAP idle cycles between polls.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready.
// Ports: cmd_* request (valid/ready), rsp_* response (valid/ready),
// eng_* bit-level engine handshake (start pulse / done pulse), busy.
module spi_flash_sequencer
  import spi_flash_pkg::*;
#(
  parameter int POLL_LIMIT = 65535,
  parameter int POLL_GAP   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        eng_start,
  output logic [6:0]  eng_len,
  output logic [63:0] eng_tx,
  input  logic        eng_done,
  input  logic [63:0] eng_rx,
  output logic        busy
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  seq_state_t     state, state_nxt;
  op_t            op_q, op_sel;
  logic [23:0]    addr_q, addr_sel;
  logic [31:0]    wdata_q, wdata_sel;
  logic           launched, launched_nxt;
  logic [PCW-1:0] poll_cnt, poll_cnt_nxt;
  logic [6:0]     len_nxt;
  logic [63:0]    tx_nxt;
  logic [31:0]    rdata_nxt;
  logic           err_nxt;
  logic           in_txn, done_ok, poll_last, entering;
  logic           gap_load, gap_expired;
  logic           unused_rx;

  // Only the low word of the receive shifter carries data.
  assign unused_rx = ^eng_rx[63:32];

  assign in_txn    = (state == S_WREN) || (state == S_OP) || (state == S_POLL);
  // A done pulse before our own launch cannot belong to our transaction.
  assign done_ok   = in_txn && launched && eng_done;
  assign eng_start = in_txn && !launched;
  assign poll_last = (poll_cnt == POLL_LAST);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // In IDLE the command is not latched yet, so the first transaction is built
  // straight from the request inputs.
  always_comb begin
    op_sel    = op_q;
    addr_sel  = addr_q;
    wdata_sel = wdata_q;
    if (state == S_IDLE) begin
      op_sel    = op_t'(cmd_op);
      addr_sel  = cmd_addr;
      wdata_sel = cmd_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if ((op_t'(cmd_op) == OP_PROGRAM) || (op_t'(cmd_op) == OP_ERASE)) begin
            state_nxt = S_WREN;
          end else begin
            state_nxt = S_OP;
          end
        end
      end
      S_WREN: begin
        if (done_ok) state_nxt = S_OP;
      end
      S_OP: begin
        if (done_ok) begin
          if ((op_q == OP_READ) || (op_q == OP_STATUS)) state_nxt = S_RESP;
          else                                          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_expired) state_nxt = S_POLL;
      end
      S_POLL: begin
        if (done_ok) begin
          if (!eng_rx[0] || poll_last) state_nxt = S_RESP;
          else                         state_nxt = S_GAP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign entering = (state_nxt != state);
  assign gap_load = entering && (state_nxt == S_GAP);

  // Datapath next values: transaction setup, response capture, counters
  always_comb begin
    len_nxt      = eng_len;
    tx_nxt       = eng_tx;
    rdata_nxt    = rsp_rdata;
    err_nxt      = rsp_err;
    poll_cnt_nxt = poll_cnt;
    launched_nxt = launched;

    // Length and tx bits are set up on entry so they are already valid in
    // the launch cycle and stay constant while the engine shifts.
    if (entering) begin
      launched_nxt = 1'b0;
      case (state_nxt)
        S_WREN: begin
          len_nxt = LEN_BYTE;
          tx_nxt  = pad_cmd8(OPC_WREN);
        end
        S_OP: begin
          case (op_sel)
            OP_READ: begin
              len_nxt = LEN_LONG;
              tx_nxt  = {OPC_READ, addr_sel, 32'hFFFF_FFFF};
            end
            OP_PROGRAM: begin
              len_nxt = LEN_LONG;
              tx_nxt  = {OPC_WRITE, addr_sel, wdata_sel};
            end
            OP_ERASE: begin
              len_nxt = LEN_BYTE;
              tx_nxt  = pad_cmd8(OPC_CHIP_ERASE);
            end
            OP_STATUS: begin
              len_nxt = LEN_STATUS;
              tx_nxt  = status_tx();
            end
            default: begin
              len_nxt = LEN_STATUS;
              tx_nxt  = status_tx();
            end
          endcase
        end
        S_POLL: begin
          len_nxt = LEN_STATUS;
          tx_nxt  = status_tx();
        end
        default: ;
      endcase
    end else if (in_txn) begin
      launched_nxt = 1'b1;
    end

    if (state == S_IDLE && entering) begin
      poll_cnt_nxt = '0;
    end

    if (done_ok && (state == S_OP)) begin
      if (op_q == OP_READ) begin
        rdata_nxt = eng_rx[31:0];
        err_nxt   = 1'b0;
      end else if (op_q == OP_STATUS) begin
        rdata_nxt = {24'h0, eng_rx[7:0]};
        err_nxt   = 1'b0;
      end
    end

    if (done_ok && (state == S_POLL)) begin
      if (!eng_rx[0] || poll_last) begin
        // WIP still set on the last permitted poll means timeout.
        rdata_nxt = {24'h0, eng_rx[7:0]};
        err_nxt   = eng_rx[0];
      end else begin
        poll_cnt_nxt = poll_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      launched  <= 1'b0;
      poll_cnt  <= '0;
      eng_len   <= '0;
      eng_tx    <= '1;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if ((state == S_IDLE) && cmd_valid) begin
        op_q    <= op_t'(cmd_op);
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      launched  <= launched_nxt;
      poll_cnt  <= poll_cnt_nxt;
      eng_len   <= len_nxt;
      eng_tx    <= tx_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_err   <= err_nxt;
    end
  end

  gap_timer #(
    .POLL_GAP(POLL_GAP)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (gap_load),
    .en      (state == S_GAP),
    .expired (gap_expired)
  );

endmodule
